// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format coding, range limits
// and the per-format range test.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_t;

    localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM12_MAX = 64'sd2047;
    localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM13_MAX = 64'sd4094;
    localparam logic signed [63:0] IMM21_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM21_MAX = 64'sd1048574;

    function automatic logic immOutOfRange(input logic signed [63:0] imm, input imm_fmt_t fmt);
        logic bad;
        case (fmt)
            IMM_B:   bad = (imm < IMM13_MIN) || (imm > IMM13_MAX);
            IMM_J:   bad = (imm < IMM21_MIN) || (imm > IMM21_MAX);
            default: bad = (imm < IMM12_MIN) || (imm > IMM12_MAX);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Scatters the low immediate bits into the selected format's fields,
// leaving every other template bit untouched.
module imm_encoder_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0] tmpl,
    input  logic [20:0] imm,
    input  imm_fmt_t    fmt,
    output logic [31:0] word
);

    always_comb begin
        word = tmpl;
        case (fmt)
            IMM_I: word[31:20] = imm[11:0];
            IMM_S: begin
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
            end
            IMM_B: begin
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
            end
            IMM_J: begin
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 checks range/alignment and keeps the low
// immediate bits, S2 holds the packed word; valid/ready on both sides.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [63:0]      in_imm,
    input  logic [1:0]       in_imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err_range,
    output logic             out_err_align,
    output logic [CNT_W-1:0] err_count
);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic               vld_p1;
    logic [31:0]        instr_p1;
    imm_fmt_t           fmt_p1;
    logic [20:0]        immLow_p1;
    logic               errRange_p1;
    logic               errAlign_p1;

    logic               vld_p2;
    logic [31:0]        instr_p2;
    logic               errRange_p2;
    logic               errAlign_p2;
    logic [CNT_W-1:0]   errCount;

    imm_fmt_t           fmtIn;
    logic signed [63:0] immIn;
    logic               stage2Ready;
    logic [31:0]        packedWord;

    assign fmtIn       = imm_fmt_t'(in_imm_src);
    assign immIn       = signed'(in_imm);
    assign stage2Ready = !vld_p2 || out_ready;
    assign in_ready    = !vld_p1 || stage2Ready;

    // Stage p0 -> p1: capture template and format, precompute the error flags
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            instr_p1    <= in_instr;
            fmt_p1      <= fmtIn;
            immLow_p1   <= in_imm[20:0];
            errRange_p1 <= immOutOfRange(immIn, fmtIn);
            errAlign_p1 <= in_imm_src[1] & in_imm[0];
        end
    end

    imm_encoder_pack u_pack (
        .tmpl (instr_p1),
        .imm  (immLow_p1),
        .fmt  (fmt_p1),
        .word (packedWord)
    );

    // Stage p1 -> p2: packed word and flags become the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            instr_p2    <= '0;
            errRange_p2 <= 1'b0;
            errAlign_p2 <= 1'b0;
            errCount    <= '0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (stage2Ready) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    instr_p2    <= packedWord;
                    errRange_p2 <= errRange_p1;
                    errAlign_p2 <= errAlign_p1;
                end
            end
            if (vld_p2 && out_ready && (errRange_p2 || errAlign_p2)) begin
                errCount <= satInc(errCount);
            end
        end
    end

    assign out_valid     = vld_p2;
    assign out_instr     = instr_p2;
    assign out_err_range = errRange_p2;
    assign out_err_align = errAlign_p2;
    assign err_count     = errCount;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder against hand-computed words
// and an independent immediate decoder.
module tb_imm_encoder;

    localparam int CW    = 4;
    localparam int NSOAK = 10000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [63:0]   in_imm;
    logic [1:0]    in_imm_src;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err_range;
    logic          out_err_align;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] t;
        logic [63:0] imm;
        logic [1:0]  src;
        logic        r;
        logic        a;
    } req_t;

    req_t q[$];

    imm_encoder #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_imm        (in_imm),
        .in_imm_src    (in_imm_src),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_err_range (out_err_range),
        .out_err_align (out_err_align),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] decode(input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'b00:   return {{52{w[31]}}, w[31:20]};
            2'b01:   return {{52{w[31]}}, w[31:25], w[11:7]};
            2'b10:   return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] fieldMask(input logic [1:0] src);
        case (src)
            2'b00:   return 32'hFFF0_0000;
            2'b11:   return 32'hFFFF_F000;
            default: return 32'hFE00_0F80;
        endcase
    endfunction

    function automatic req_t genReq();
        req_t r;
        int   sel;
        logic signed [63:0] v;
        logic signed [63:0] lo;
        logic signed [63:0] hi;
        r.t   = $urandom;
        r.src = 2'($urandom_range(0, 3));
        sel   = $urandom_range(0, 7);
        v     = signed'({32'($urandom), 32'($urandom)});
        if (sel != 0) begin
            case (r.src)
                2'b10:   v = v >>> 51;
                2'b11:   v = v >>> 43;
                default: v = v >>> 52;
            endcase
            if (r.src[1] && sel != 1) v[0] = 1'b0;
        end
        r.imm = v;
        case (r.src)
            2'b10:   begin lo = -64'sd4096;    hi = 64'sd4094;    end
            2'b11:   begin lo = -64'sd1048576; hi = 64'sd1048574; end
            default: begin lo = -64'sd2048;    hi = 64'sd2047;    end
        endcase
        r.r = (v < lo) || (v > hi);
        r.a = r.src[1] & v[0];
        return r;
    endfunction

    task automatic drive(input logic [31:0] t, input logic [63:0] imm, input logic [1:0] src);
        in_instr   = t;
        in_imm     = imm;
        in_imm_src = src;
        in_valid   = 1'b1;
    endtask

    // One request through an empty pipeline with out_ready held high.
    task automatic single(input string tag, input logic [31:0] t, input logic [63:0] imm,
                          input logic [1:0] src, input logic [31:0] expW,
                          input logic expR, input logic expA, input logic [CW-1:0] expCnt);
        @(negedge clk);
        drive(t, imm, src);
        check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_word"}, 64'(out_instr), 64'(expW));
        check({tag, "_range"}, 64'(out_err_range), 64'(expR));
        check({tag, "_align"}, 64'(out_err_align), 64'(expA));
        @(negedge clk);
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
        check({tag, "_cnt"}, 64'(err_count), 64'(expCnt));
    endtask

    initial begin
        req_t cur;
        req_t exp;
        logic acc;
        int   sent;
        int   got;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm     = '0;
        in_imm_src = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_word", 64'(out_instr), 64'd0);
        check("rst_range", 64'(out_err_range), 64'd0);
        check("rst_align", 64'(out_err_align), 64'd0);
        check("rst_cnt", 64'(err_count), 64'd0);
        check("rst_inrdy", 64'(in_ready), 64'd1);

        single("I", 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 32'hFFF0_0013, 1'b0, 1'b0, 4'd0);
        single("S", 32'h0000_3023, 64'd8, 2'b01, 32'h0000_3423, 1'b0, 1'b0, 4'd0);
        single("B", 32'h0000_0063, -64'sd4, 2'b10, 32'hFE00_0EE3, 1'b0, 1'b0, 4'd0);
        single("J", 32'h0000_006F, 64'd8, 2'b11, 32'h0080_006F, 1'b0, 1'b0, 4'd0);
        single("I_rng", 32'h0000_0013, 64'd2048, 2'b00, 32'h8000_0013, 1'b1, 1'b0, 4'd1);
        single("B_ok", 32'h0000_0063, 64'd6, 2'b10, 32'h0000_0363, 1'b0, 1'b0, 4'd1);
        single("B_aln", 32'h0000_0063, 64'd5, 2'b10, 32'h0000_0263, 1'b0, 1'b1, 4'd2);
        for (int i = 3; i <= 15; i++) begin
            single("cnt_up", 32'h0000_0013, 64'd4096, 2'b00, 32'h0000_0013, 1'b1, 1'b0, 4'(i));
        end
        single("cnt_sat", 32'h0000_0013, 64'd4096, 2'b00, 32'h0000_0013, 1'b1, 1'b0, 4'd15);

        // Back-pressure: two accepted, third stalls, then all drain in order
        out_ready = 1'b0;
        @(negedge clk);
        drive(32'h0000_0013, 64'd1, 2'b00);
        check("bp_acc1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(32'h0000_3023, -64'sd8, 2'b01);
        check("bp_acc2", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(32'h0000_006F, -64'sd2, 2'b11);
        check("bp_stall", 64'(in_ready), 64'd0);
        check("bp_hold_vld", 64'(out_valid), 64'd1);
        check("bp_hold_word", 64'(out_instr), 64'h0010_0013);
        @(negedge clk);
        check("bp_stall2", 64'(in_ready), 64'd0);
        check("bp_hold_word2", 64'(out_instr), 64'h0010_0013);
        out_ready = 1'b1;
        #1;
        check("bp_release", 64'(in_ready), 64'd1);
        check("bp_out_a", 64'(out_instr), 64'h0010_0013);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_vld_b", 64'(out_valid), 64'd1);
        check("bp_out_b", 64'(out_instr), 64'hFE00_3C23);
        @(negedge clk);
        check("bp_vld_c", 64'(out_valid), 64'd1);
        check("bp_out_c", 64'(out_instr), 64'hFFFF_F06F);
        @(negedge clk);
        check("bp_nodup", 64'(out_valid), 64'd0);
        check("bp_cnt", 64'(err_count), 64'd15);

        // Reset with two erroring entries in flight
        out_ready = 1'b0;
        @(negedge clk);
        drive(32'h0000_0013, 64'd4096, 2'b00);
        @(negedge clk);
        drive(32'h0000_0063, 64'd3, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_vld", 64'(out_valid), 64'd0);
        check("mid_rst_cnt", 64'(err_count), 64'd0);
        check("mid_rst_inrdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_stale", 64'(out_valid), 64'd0);
        end
        check("mid_rst_cnt2", 64'(err_count), 64'd0);

        // Random soak with random source/sink pacing
        acc  = 1'b0;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80000 && got < NSOAK; cyc++) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            if (!in_valid && sent < NSOAK && $urandom_range(0, 3) != 0) begin
                cur = genReq();
                drive(cur.t, cur.imm, cur.src);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("soak_extra", 64'(out_valid), 64'd0);
                end else begin
                    exp = q.pop_front();
                    got++;
                    check("soak_range", 64'(out_err_range), 64'(exp.r));
                    check("soak_align", 64'(out_err_align), 64'(exp.a));
                    check("soak_tmpl", 64'((out_instr ^ exp.t) & ~fieldMask(exp.src)), 64'd0);
                    if (!exp.r && !exp.a) begin
                        check("soak_roundtrip", decode(out_instr, exp.src), exp.imm);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                acc = 1'b1;
            end
        end
        check("soak_count", 64'(got), 64'(NSOAK));
        check("soak_left", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extractor. Takes a 32-bit instruction template, a 64-bit immediate and the format select. Writes the immediate into that format's scattered bit fields and returns the finished instruction word.
- Used by the trap/patch path and the self-check harness to build instruction words, such as branch and jump fix-ups.
- Two-stage pipeline with valid/ready handshake on both sides, range and alignment checking, and a saturating error counter.

Parameters:
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_instr  in  32 (u32)  template instruction (opcode/rd/rs1/rs2/funct bits)
- in_imm  in  64 (u64)  signed immediate, two's complement
- in_imm_src  in  2 (u2)  format select: 00 I, 01 S, 10 B, 11 J (same coding as the decoder's immSrc)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_instr  out  32 (u32)  encoded instruction
- out_err_range  out  1  immediate outside the format's range
- out_err_align  out  1  B/J immediate has bit0 set
- err_count  out  CNT_W  saturating count of results emitted with any error bit set

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, both error bits 0, err_count=0.
  - in_ready=1 in the first cycle after reset is deasserted.
  - Reset asserted mid-operation discards all in-flight entries; nothing is emitted afterwards.
- Handshake:
  - A transfer happens on a cycle where valid and ready are both 1.
  - Source side: in_valid, in_instr, in_imm and in_imm_src must stay stable while in_ready=0.
  - Sink side: out_* hold stable while out_valid=1 and out_ready=0.
  - in_ready = !s1_valid || !s2_valid || out_ready. Combinational from out_ready; no combinational path from in_* to out_*.
- Pipeline:
  - S1 registers the template and format. It also computes and registers the range and alignment flags and the low 21 immediate bits.
  - S2 registers the packed word and the flags. S2 is the output stage.
  - Latency is 2 cycles from input transfer to out_valid when there is no stall. Throughput is 1 per cycle.
  - Results come out in order. No entry is dropped or duplicated under any out_ready pattern.
- Range rules (signed value of the full 64-bit in_imm):
  - I and S: -2048..2047.
  - B: -4096..4094; bit0 must be 0.
  - J: -1048576..1048574; bit0 must be 0.
  - I and S never raise err_align.
- Packing. Only the listed bits are overwritten; all other bits come from the template unchanged:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Errors:
  - On any error the word is still packed from the truncated imm bits, and the error bits are set.
  - Bit0 of a B/J immediate is always dropped.
- err_count increments once per output transfer that has an error bit set. It saturates at all-ones.
- Round-trip guarantee: when both error bits are 0, the decoder applied to out_instr with the same immSrc returns exactly in_imm.

Decomposition:
- Shared package (common.sv):
  - enum imm_fmt_t {IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11}; the decoder switches to this enum too.
  - Range constants IMM12_MIN/MAX, IMM13_MIN/MAX, IMM21_MIN/MAX.
- One sub-module: imm_pack, combinational (template, imm[20:0], fmt -> packed u32), instantiated in S2.
  - Kept separate so the bench can check it exhaustively against the decoder.

Test Plan:
- I: template 0x00000013, imm=-1 (0xFFFF_FFFF_FFFF_FFFF), fmt 00 -> out_instr 0xFFF00013, no errors, out_valid exactly 2 cycles after the input transfer.
- S: template 0x00003023, imm=8 -> 0x00003423.
- B: template 0x00000063, imm=-4 -> 0xFE000EE3.
- J: template 0x0000006F, imm=8 -> 0x0080006F.
- Errors:
  - I imm=2048 -> err_range=1, err_count 0->1.
  - B imm=6 -> no error; B imm=5 -> err_align=1, err_count 1->2.
  - Forcing the counter to all-ones and sending another error -> err_count holds at all-ones.
- Back-pressure and reset:
  - out_ready=0, offer 3 back-to-back requests -> two are accepted, then in_ready=0 with outputs stable.
  - Raise out_ready -> the 3 results come out in order, with no loss or duplication.
  - Assert reset with 2 entries in flight -> out_valid=0 next cycle, err_count=0, no stale result afterwards.
  - Random soak of 10k requests: every result with no error bits round-trips through the decoder to in_imm.
